// File: rtl/rng_pkg.sv
// Shared types and helpers for the RNG post-processing stages.
package rng_pkg;

   localparam int unsigned SAMPLE_WIDTH = 16;

   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Smallest 2^k-1 covering rng-1; rng=1 yields 0. Never called with rng=0.
   function automatic logic [31:0] mask_of(input logic [31:0] rng);
      logic [31:0] m;
      m = rng - 32'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      return m;
   endfunction

endpackage

// File: rtl/rng_fifo.sv
// Synchronous FIFO with wrap-bit pointers, registered head and flush.
module rng_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wr_ptr, rd_ptr, wr_n, rd_n;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] data_n;
   logic             valid_n, do_push, do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Next pointers and next head; a push into an empty (or just-drained) FIFO bypasses to the head.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_n    = wr_ptr + PW'(do_push);
      rd_n    = rd_ptr + PW'(do_pop);
      valid_n = (wr_n != rd_n);
      data_n  = data;
      if (valid_n) begin
         if (do_push && (wr_ptr[AW-1:0] == rd_n[AW-1:0])) begin
            data_n = push_data;
         end else begin
            data_n = mem[rd_n[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         valid  <= 1'b0;
         data   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         valid  <= 1'b0;
         data   <= '0;
      end else begin
         wr_ptr <= wr_n;
         rd_ptr <= rd_n;
         valid  <= valid_n;
         data   <= data_n;
      end
   end

endmodule

// File: rtl/lfsr_range_sampler.sv
// Mask-and-reject sampler turning LFSR words into uniform values in [0, N).
// Optional RAND_STATS_EN adds saturating accept/reject counters.
module lfsr_range_sampler
   import rng_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = SAMPLE_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_word,
   input  logic             in_valid,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_range,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             rejected
`ifdef RAND_STATS_EN
   ,
   output logic [31:0]      stat_accept,
   output logic [31:0]      stat_reject
`endif
);

   state_t           state, state_n;
   logic [WIDTH-1:0] range_q, mask_q, cand;
   logic             cfg_take, flush, in_range, run_word;
   logic             push_req, push_ok, pop_ok, fifo_full, fifo_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= UNCFG;
      end else begin
         state <= state_n;
      end
   end

   // Next state; a new range is taken in UNCFG or RUN, never during LOAD.
   always_comb begin
      state_n  = state;
      cfg_take = 1'b0;
      case (state)
         UNCFG, RUN: begin
            if (cfg_valid && (cfg_range != '0)) begin
               cfg_take = 1'b1;
               state_n  = LOAD;
            end
         end
         LOAD:    state_n = RUN;
         default: state_n = UNCFG;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         range_q <= '0;
         mask_q  <= '0;
      end else begin
         if (cfg_take) begin
            range_q <= cfg_range;
         end
         if (state == LOAD) begin
            mask_q <= WIDTH'(mask_of(32'(range_q)));
         end
      end
   end

   // Stale samples are dropped as soon as a new range is accepted and again in LOAD.
   assign flush    = cfg_take || (state == LOAD);
   assign cand     = in_word & mask_q;
   assign in_range = (cand < range_q);
   assign run_word = (state == RUN) && in_valid;
   assign push_req = run_word && in_range && !cfg_take;
   assign rejected = run_word && !in_range;
   assign busy     = (state != RUN);
   assign pop_ok   = out_ready && !fifo_empty;
   assign push_ok  = push_req && (!fifo_full || pop_ok);

   rng_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .flush     (flush),
      .push      (push_req),
      .push_data (cand),
      .pop       (out_ready),
      .data      (out_data),
      .valid     (out_valid),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef RAND_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_accept <= '0;
         stat_reject <= '0;
      end else if (flush) begin
         stat_accept <= '0;
         stat_reject <= '0;
      end else begin
         if (push_ok && (stat_accept != 32'hFFFF_FFFF)) begin
            stat_accept <= stat_accept + 32'd1;
         end
         if (rejected && (stat_reject != 32'hFFFF_FFFF)) begin
            stat_reject <= stat_reject + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/lfsr_range_sampler.md
Name: lfsr_range_sampler

Overview:
- Downstream consumer of the 16-bit free-running LFSR word stream.
- Converts raw LFSR words into uniformly distributed integers in [0, N) by mask-and-reject sampling.
- Buffers accepted samples in a small FIFO and presents them on a valid/ready interface to downstream users (dice, test-pattern, shuffle logic).
- N is programmable at run time through a one-cycle config strobe.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, 2..16.
- WIDTH, 16, LFSR word and sample width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_word  in  WIDTH  current LFSR register value.
- in_valid  in  1  in_word is a fresh value this cycle; high every cycle when the LFSR free-runs.
- cfg_valid  in  1  one-cycle strobe to load a new range.
- cfg_range  in  WIDTH  range N; sampled when cfg_valid=1.
- out_data  out  WIDTH  sample in [0, N-1]; FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts out_data when out_valid & out_ready.
- busy  out  1  state is not RUN.
- rejected  out  1  pulse: current in_word was discarded as out of range.

Behaviour:
- Reset (reset=0, async) values:
  - State UNCFG; FIFO empty, pointers 0.
  - out_valid=0, out_data=0, busy=1, rejected=0.
  - Stored range=0, mask=0.
- State UNCFG: ignores in_valid. cfg_valid with cfg_range>=1 -> LOAD. cfg_range=0 is ignored and the block stays in UNCFG.
- State LOAD (exactly 1 cycle):
  - mask = (range-1) with all bits below its MSB set, i.e. the smallest 2^k-1 >= range-1.
  - range=1 gives mask=0.
  - FIFO is flushed: pointers reset, out_valid=0 next cycle.
  - Transition to RUN.
- State RUN, each cycle with in_valid=1:
  - cand = in_word & mask.
  - If cand < range and the FIFO is not full (or is full but a pop occurs this cycle), push cand.
  - Else if cand >= range: rejected=1 for that cycle, no push.
  - If the FIFO is full with no pop, the word is dropped silently. rejected=0; this is not a rejection.
- Latency: in_word in cycle t appears at out_data in cycle t+1 when the FIFO was empty. out_valid rises in t+1.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits with wrap bit; full/empty derived from the pointers.
  - Push and pop in the same cycle is legal in every fill level, including full (count unchanged) and empty (no pop occurs since out_valid=0).
  - out_data is the registered head. It must be stable while out_valid=1 and out_ready=0.
- Reconfiguration: cfg_valid in RUN with cfg_range>=1 -> LOAD. The FIFO is flushed, including stale samples from the old range. cfg_range=0 in RUN is ignored.
- cfg_valid during LOAD is ignored.
- busy=1 in UNCFG and LOAD, 0 in RUN.
- The full range N=2^WIDTH is not representable; cfg_range is WIDTH bits and the maximum is 2^WIDTH-1.
- All comparisons are unsigned, at WIDTH bits.

Optional Feature:
- Macro RAND_STATS_EN.
- Defined:
  - Adds outputs stat_accept[31:0] and stat_reject[31:0].
  - stat_accept counts pushes; stat_reject counts rejected pulses.
  - Both saturate at 0xFFFFFFFF. Both clear on reset and on entry to LOAD.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package rng_pkg:
  - State enum (UNCFG, LOAD, RUN).
  - Constant WIDTH=16 default.
  - Function mask_of(range) performing the bit-smear.
- Sub-module rng_fifo (synchronous FIFO; DEPTH, WIDTH parameters; push/pop/full/empty/flush), reusable by later RNG stages.
- Sampler FSM and compare stay in the top.

Test Plan:
- Reset then cfg_range=6 -> mask=7.
  - Drive in_word 0x5678 (cand=0) -> out_data=0 next cycle.
  - 0x000F (cand=7) -> rejected=1, no push.
  - 0x0005 -> push 5.
- cfg_range=1, out_ready=1, in_valid every cycle with arbitrary words -> every sample is 0, rejected never asserts, one output per cycle.
- cfg_range=16 (mask=15), out_ready=0, DEPTH=4, feed 0x1,0x2,0x3,0x4,0x5 -> out_valid=1 with out_data held at 1. 0x5 is dropped with rejected=0. Raise out_ready -> pops 1,2,3,4, then out_valid=0.
- FIFO full, out_ready=1, in_word=0x9 -> simultaneous push/pop, count stays 4, tail order 2,3,4,9.
- With 3 samples queued, cfg_valid with cfg_range=100 -> busy=1 for one cycle, out_valid=0, then only values <100 appear (mask=127). cfg_range=0 in RUN -> no effect.
- Reset asserted mid-stream with FIFO non-empty -> out_valid=0 immediately (async), state UNCFG, and no output until a new config.
- With RAND_STATS_EN defined, the last scenario -> stats zero after reset and after LOAD.
